// File: rtl/hook_motion_ctrl.sv
// Hook motion controller: swing, extend, retract; one draw_hook request per accepted tick.
// Optional HOOK_WEIGHT_EN: retract step shrinks with the weight class of the grabbed object.
module hook_motion_ctrl #(
  parameter int DEG_MIN    = 0,
  parameter int DEG_MAX    = 140,
  parameter int DEG_INIT   = 70,
  parameter int SWING_STEP = 2,
  parameter int LEN_MIN    = 20,
  parameter int LEN_MAX    = 300,
  parameter int EXT_STEP   = 4,
  parameter int RET_STEP   = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tick,
  input  logic       fire,
  input  logic       grabbed,
  input  logic [1:0] weight,
  input  logic       draw_done,
  output logic [8:0] degree,
  output logic [9:0] length,
  output logic       draw_enable,
  output logic [1:0] state,
  output logic       returned,
  output logic       caught,
  output logic       tick_dropped
);

  typedef enum logic [1:0] {
    SWING   = 2'd0,
    EXTEND  = 2'd1,
    RETRACT = 2'd2
  } st_t;

  localparam logic [9:0] DMIN = 10'(DEG_MIN);
  localparam logic [9:0] DMAX = 10'(DEG_MAX);
  localparam logic [9:0] SSTP = 10'(SWING_STEP);
  localparam logic [9:0] LMIN = 10'(LEN_MIN);
  localparam logic [9:0] LMAX = 10'(LEN_MAX);
  localparam logic [9:0] ESTP = 10'(EXT_STEP);
  localparam logic [9:0] RSTP = 10'(RET_STEP);

  st_t        st;
  logic       dir_up;
  logic       busy;
  logic       fire_pend;
  logic       caught_lat;
  logic       acc;
  logic       pend;
  logic [9:0] deg_up;
  logic [9:0] deg_dn;
  logic       hit_hi;
  logic       hit_lo;
  logic [9:0] len_ext;
  logic [9:0] step;
  logic       hit_rest;

`ifdef HOOK_WEIGHT_EN
  logic [9:0] shifted;
  always_comb begin
    shifted = RSTP >> weight;
    step    = (shifted == 10'd0) ? 10'd1 : shifted;
  end
`else
  logic unused_weight;
  assign unused_weight = ^weight;
  assign step = RSTP;
`endif

  always_comb begin
    // a done arriving with a tick frees the drawer first
    acc      = tick & (~busy | draw_done);
    pend     = fire_pend | (fire & (st == SWING));
    deg_up   = {1'b0, degree} + SSTP;
    deg_dn   = {1'b0, degree} - SSTP;
    hit_hi   = deg_up >= DMAX;
    hit_lo   = {1'b0, degree} <= DMIN + SSTP;
    len_ext  = length + ESTP;
    hit_rest = length <= LMIN + step;
  end

  assign state = st;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st           <= SWING;
      degree       <= 9'(DEG_INIT);
      dir_up       <= 1'b1;
      length       <= LMIN;
      busy         <= 1'b0;
      fire_pend    <= 1'b0;
      caught_lat   <= 1'b0;
      draw_enable  <= 1'b0;
      returned     <= 1'b0;
      caught       <= 1'b0;
      tick_dropped <= 1'b0;
    end else begin
      draw_enable  <= acc;
      tick_dropped <= tick & busy & ~draw_done;
      returned     <= 1'b0;
      caught       <= 1'b0;
      fire_pend    <= pend;
      if (draw_enable) busy <= 1'b1;
      else if (draw_done) busy <= 1'b0;
      if (acc) begin
        unique case (st)
          SWING: begin
            if (pend) begin
              st        <= EXTEND;
              fire_pend <= 1'b0;
            end else if (dir_up) begin
              degree <= hit_hi ? DMAX[8:0] : deg_up[8:0];
              if (hit_hi) dir_up <= 1'b0;
            end else begin
              degree <= hit_lo ? DMIN[8:0] : deg_dn[8:0];
              if (hit_lo) dir_up <= 1'b1;
            end
          end
          EXTEND: begin
            if (grabbed) begin
              caught_lat <= 1'b1;
              st         <= RETRACT;
            end else if (len_ext >= LMAX) begin
              length     <= LMAX;
              caught_lat <= 1'b0;
              st         <= RETRACT;
            end else begin
              length <= len_ext;
            end
          end
          RETRACT: begin
            if (hit_rest) begin
              length     <= LMIN;
              st         <= SWING;
              returned   <= 1'b1;
              caught     <= caught_lat;
              caught_lat <= 1'b0;
            end else begin
              length <= length - step;
            end
          end
          default: st <= SWING;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hook_motion_ctrl.sv
// Bench for hook_motion_ctrl: directed scenarios plus random traffic.
// Outputs are compared every cycle with a behavioural hook model.
module tb_hook_motion_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       tick, fire, grabbed, draw_done;
  logic [1:0] weight;
  logic [8:0] degree;
  logic [9:0] length;
  logic       draw_enable, returned, caught, tick_dropped;
  logic [1:0] state;

  hook_motion_ctrl dut (
    .clock(clock), .resetn(resetn), .tick(tick), .fire(fire),
    .grabbed(grabbed), .weight(weight), .draw_done(draw_done),
    .degree(degree), .length(length), .draw_enable(draw_enable),
    .state(state), .returned(returned), .caught(caught),
    .tick_dropped(tick_dropped)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // model of the hook: angle, rope, phase, outstanding draw
  int m_deg, m_len, m_st;
  bit m_up, m_pend, m_clat, m_busy;
  bit e_en, e_ret, e_caught, e_drop;

  int done_cnt = 0;
  int dly = 3;
  bit spur = 0;
  int en_cnt = 0;
  bit seen_ret = 0;
  bit seen_caught = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_deg = 70; m_len = 20; m_st = 0; m_up = 1;
    m_pend = 0; m_clat = 0; m_busy = 0;
    e_en = 0; e_ret = 0; e_caught = 0; e_drop = 0;
  endtask

  function automatic int ret_step(input int w);
`ifdef HOOK_WEIGHT_EN
    int s;
    s = 4 >> w;
    return (s < 1) ? 1 : s;
`else
    return 4;
`endif
  endfunction

  task automatic model_step();
    bit acc, pend, nbusy;
    int s;
    acc    = tick && (!m_busy || draw_done);
    e_drop = tick && m_busy && !draw_done;
    nbusy  = e_en ? 1'b1 : (draw_done ? 1'b0 : m_busy);
    pend   = m_pend || (fire && m_st == 0);
    e_ret = 0; e_caught = 0;
    if (acc) begin
      if (m_st == 0) begin
        if (pend) begin
          m_st = 1; pend = 0;
        end else if (m_up) begin
          m_deg = m_deg + 2;
          if (m_deg >= 140) begin m_deg = 140; m_up = 0; end
        end else begin
          m_deg = m_deg - 2;
          if (m_deg <= 0) begin m_deg = 0; m_up = 1; end
        end
      end else if (m_st == 1) begin
        if (grabbed) begin
          m_clat = 1; m_st = 2;
        end else if (m_len + 4 >= 300) begin
          m_len = 300; m_clat = 0; m_st = 2;
        end else m_len += 4;
      end else begin
        s = ret_step(int'(weight));
        if (m_len <= 20 + s) begin
          m_len = 20; m_st = 0; e_ret = 1; e_caught = m_clat; m_clat = 0;
        end else m_len -= s;
      end
    end
    m_pend = pend;
    e_en   = acc;
    m_busy = nbusy;
  endtask

  task automatic cmp_all();
    check("degree", int'(degree), m_deg);
    check("length", int'(length), m_len);
    check("state", int'(state), m_st);
    check("draw_enable", int'(draw_enable), int'(e_en));
    check("returned", int'(returned), int'(e_ret));
    check("caught", int'(caught), int'(e_caught));
    check("tick_dropped", int'(tick_dropped), int'(e_drop));
  endtask

  task automatic cyc(input bit tk, input bit fr, input bit gr, input logic [1:0] wt);
    @(negedge clock);
    tick = tk; fire = fr; grabbed = gr; weight = wt;
    draw_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) draw_done = 1'b1;
    end else if (spur && $urandom_range(0, 19) == 0) draw_done = 1'b1;
    @(posedge clock);
    model_step();
    #1;
    cmp_all();
    if (e_en) done_cnt = (dly == 0) ? int'($urandom_range(1, 4)) : dly;
    if (draw_enable) en_cnt++;
    if (returned) begin seen_ret = 1; seen_caught = caught; end
  endtask

  task automatic tick_wait(input bit gr, input logic [1:0] wt);
    cyc(1, 0, gr, wt);
    repeat (dly + 1) cyc(0, 0, gr, wt);
  endtask

  initial begin
    resetn = 0; tick = 0; fire = 0; grabbed = 0; weight = 0; draw_done = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    cmp_all();
    @(negedge clock);
    resetn = 1;

    // swing across the upper bound
    dly = 3;
    repeat (35) tick_wait(0, 0);
    check("swing_top", int'(degree), 140);
    check("enables", en_cnt, 35);
    tick_wait(0, 0);
    check("swing_back", int'(degree), 138);

    // launch, run to full length, come back empty
    cyc(0, 1, 0, 0);
    tick_wait(0, 0);
    check("launch_state", int'(state), 1);
    repeat (70) tick_wait(0, 0);
    check("max_len", int'(length), 300);
    check("max_state", int'(state), 2);
    seen_ret = 0;
    for (int i = 0; i < 100 && m_st != 0; i++) tick_wait(0, 0);
    check("empty_ret", int'(seen_ret), 1);
    check("empty_caught", int'(seen_caught), 0);

    // grab at length 100
    cyc(0, 1, 0, 0);
    tick_wait(0, 0);
    repeat (20) tick_wait(0, 0);
    check("len100", int'(length), 100);
    tick_wait(1, 0);
    check("grab_state", int'(state), 2);
    check("grab_len", int'(length), 100);
    seen_ret = 0;
    repeat (20) tick_wait(0, 0);
    check("grab_ret", int'(seen_ret), 1);
    check("grab_caught", int'(seen_caught), 1);
    check("grab_home", int'(state), 0);

    // tick while a draw is in flight
    dly = 6;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("drop_pulse", int'(tick_dropped), 1);
    check("drop_no_en", int'(draw_enable), 0);
    repeat (6) cyc(0, 0, 0, 0);

    // weighted retract from length 32
    dly = 2;
    cyc(0, 1, 0, 0);
    tick_wait(0, 0);
    repeat (3) tick_wait(0, 0);
    tick_wait(1, 2);
    check("w_start", int'(length), 32);
    for (int i = 1; i <= 12 && m_st == 2; i++) begin
      tick_wait(0, 2);
`ifdef HOOK_WEIGHT_EN
      check("w_len", int'(length), 32 - i);
`else
      check("w_len", int'(length), (32 - 4 * i < 20) ? 20 : 32 - 4 * i);
`endif
    end
    check("w_home", int'(state), 0);

    // reset while busy in RETRACT
    dly = 6;
    cyc(0, 1, 0, 0);
    tick_wait(0, 0);
    repeat (3) tick_wait(0, 0);
    tick_wait(1, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    tick = 0; fire = 0; draw_done = 0;
    #2 resetn = 0;
    #1;
    model_reset();
    check("rst_state", int'(state), 0);
    check("rst_degree", int'(degree), 70);
    check("rst_length", int'(length), 20);
    @(negedge clock);
    resetn = 1;
    repeat (6) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("post_rst_en", int'(draw_enable), 1);
    repeat (7) cyc(0, 0, 0, 0);

    // random traffic
    dly = 0; spur = 1;
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
